// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: serial MSB-first 2-bit-slice magnitude comparator with valid/ready handshakes.
// Define COMP_SEQ_EARLY_EXIT_EN to finish on the first differing slice.
module comp_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int SLICES = WIDTH / 2,
  parameter int CW = $clog2(SLICES) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Less,
  output logic             Equal,
  output logic [CW-1:0]    Count
);
  localparam int IW = SLICES > 1 ? $clog2(SLICES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             eq_q, lacc_q, less_q, equal_q;
  logic [CW-1:0]    cnt_q, count_q;
  logic [1:0]       a_s, b_s;
  logic             eq_d, less_d, fin;
  logic [CW-1:0]    cnt_d;
  assign a_s    = 2'(a_q >> {idx_q, 1'b0});
  assign b_s    = 2'(b_q >> {idx_q, 1'b0});
  assign less_d = lacc_q | (eq_q & (a_s < b_s));
  assign eq_d   = eq_q & (a_s == b_s);
  assign cnt_d  = cnt_q + CW'(1);
`ifdef COMP_SEQ_EARLY_EXIT_EN
  assign fin = (idx_q == '0) || (a_s != b_s);
`else
  assign fin = idx_q == '0;
`endif
  assign In_Ready  = state_q == IDLE;
  assign Out_Valid = state_q == DONE;
  assign Less      = less_q;
  assign Equal     = equal_q;
  assign Count     = count_q;
  // Result registers load only on finish so they stay stable through IDLE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lacc_q  <= 1'b0;
      cnt_q   <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (In_Valid) begin
          a_q     <= A;
          b_q     <= B;
          idx_q   <= IW'(SLICES - 1);
          eq_q    <= 1'b1;
          lacc_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          lacc_q <= less_d;
          eq_q   <= eq_d;
          cnt_q  <= cnt_d;
          if (fin) begin
            less_q  <= less_d;
            equal_q <= eq_d;
            count_q <= cnt_d;
            state_q <= DONE;
          end else idx_q <= idx_q - IW'(1);
        end
        DONE: if (Out_Ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl: directed self-checking bench for comp_seq_ctrl (WIDTH=8).
module tb_comp_seq_ctrl;
`ifdef COMP_SEQ_EARLY_EXIT_EN
  localparam int EE = 1;
`else
  localparam int EE = 0;
`endif
  logic       Clk, Rst_n, In_Valid, In_Ready, Out_Valid, Out_Ready, Less, Equal;
  logic [7:0] A, B;
  logic [2:0] Count;
  int total, bad;
  comp_seq_ctrl #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Less(Less), .Equal(Equal), .Count(Count)
  );
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!Out_Valid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic el, input logic eq, input int k);
    A = a; B = b; In_Valid = 1;
    @(posedge Clk); #1;
    In_Valid = 0;
    A = ~a; B = ~b;
    chk({tag, "_rdy_run"}, In_Ready, 0);
    wait_done(tag, k);
    chk({tag, "_less"}, Less, el);
    chk({tag, "_eq"}, Equal, eq);
    chk({tag, "_cnt"}, Count, k);
    Out_Ready = 1;
    @(posedge Clk); #1;
    Out_Ready = 0;
    chk({tag, "_ov_clr"}, Out_Valid, 0);
    chk({tag, "_rdy_idle"}, In_Ready, 1);
    chk({tag, "_less_held"}, Less, el);
    chk({tag, "_cnt_held"}, Count, k);
  endtask
  initial begin
    logic seen;
    total = 0; bad = 0;
    Rst_n = 0; In_Valid = 0; Out_Ready = 0; A = 0; B = 0;
    #1;
    chk("rst_rdy", In_Ready, 1);
    chk("rst_ov", Out_Valid, 0);
    chk("rst_less", Less, 0);
    chk("rst_eq", Equal, 0);
    chk("rst_cnt", Count, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    @(posedge Clk); #1;
    run_op("eq5a", 8'h5A, 8'h5A, 0, 1, 4);
    run_op("lt3f", 8'h3F, 8'h80, 1, 0, EE ? 1 : 4);
    run_op("gtc0", 8'hC0, 8'h80, 0, 0, EE ? 1 : 4);
    run_op("lt12", 8'h12, 8'h13, 1, 0, 4);
    A = 8'h01; B = 8'h02; In_Valid = 1;
    @(posedge Clk); #1;
    A = 8'h55; B = 8'h00;
    wait_done("bp", 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("bp_ov", Out_Valid, 1);
      chk("bp_less", Less, 1);
      chk("bp_cnt", Count, 4);
      chk("bp_rdy", In_Ready, 0);
    end
    Out_Ready = 1;
    @(posedge Clk); #1;
    Out_Ready = 0;
    chk("bp_rdy_after", In_Ready, 1);
    @(posedge Clk); #1;
    In_Valid = 0;
    chk("bp_acc", In_Ready, 0);
    wait_done("bp2", EE ? 1 : 4);
    chk("bp2_less", Less, 0);
    chk("bp2_eq", Equal, 0);
    chk("bp2_cnt", Count, EE ? 1 : 4);
    Out_Ready = 1;
    @(posedge Clk); #1;
    Out_Ready = 0;
    A = 8'h00; B = 8'hFF; In_Valid = 1;
    @(posedge Clk); #1;
    In_Valid = 0;
    @(posedge Clk); #1;
    Rst_n = 0;
    #1;
    chk("mr_ov", Out_Valid, 0);
    chk("mr_less", Less, 0);
    chk("mr_eq", Equal, 0);
    chk("mr_cnt", Count, 0);
    chk("mr_rdy", In_Ready, 1);
    @(negedge Clk);
    Rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      seen |= Out_Valid;
    end
    chk("mr_no_result", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
